video_stream_src: RTL and testbench

Video stream source that regenerates the `{pixel, de, hsync, vsync}` raster stream consumed by the filter chain (Sobel, skin segmentation). It is the transmitting end of that stream interface. A programmable raster timing generator walks a frame, fetches one 8-bit pixel per active position from a synchronous-read frame memory, and emits pixels together with timing signals that are aligned with them. Used for playback of stored frames and for bench and in-system testing of downstream filters.

---
 rtl/video_stream_src.sv | 161 ++++++++++++++++
 tb/tb_video_stream_src.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/video_stream_src.sv
// Raster timing generator that replays a stored 8-bit frame as a {pixel, de, hsync, vsync}
// stream; counters -> memory request -> memory data -> registered outputs (3 ce cycles).
module video_stream_src #(
  parameter int H_ACTIVE = 64,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 7,
  parameter int V_ACTIVE = 48,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        enable,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  out_bin,
  output logic        out_de,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } flags_t;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [15:0]   pix_q, pix_d;

  flags_t        flg_b_q, flg_b_d;
  flags_t        flg_c_q, flg_c_d;
  logic          rd_en_q, rd_en_d;
  logic [15:0]   rd_addr_q, rd_addr_d;
  logic          a0_c_q, a0_c_d;

  logic [7:0]    bin_q, bin_d;
  flags_t        flg_o_q, flg_o_d;
  logic          fs_q, fs_d;

  logic          running, h_last, v_last, f_last;
  flags_t        flg_a;
  logic [15:0]   addr_a;

  // Stage A: position decode; flags are forced low whenever the FSM is idle.
  always_comb begin
    running  = (state_q != IDLE);
    h_last   = (h_q == H_LAST);
    v_last   = (v_q == V_LAST);
    f_last   = h_last && v_last;
    flg_a.de = running && (h_q < H_ACT) && (v_q < V_ACT);
    flg_a.hs = running && (h_q >= HS_BEG) && (h_q < HS_END);
    flg_a.vs = running && (v_q >= VS_BEG) && (v_q < VS_END);
    addr_a   = (h_q == '0 && v_q == '0) ? 16'd0 : pix_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = f_last ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)      state_d = RUN;
        else if (f_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Raster counters and the running pixel address; the address is advanced by
  // counting active positions, so no v*H_ACTIVE product is ever formed.
  always_comb begin
    h_d   = '0;
    v_d   = '0;
    pix_d = '0;
    if (running) begin
      h_d   = h_last ? '0 : h_q + 1'b1;
      v_d   = h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;
      pix_d = flg_a.de ? addr_a + 16'd1 : addr_a;
    end
  end

  always_comb begin
    rd_en_d   = flg_a.de;
    rd_addr_d = flg_a.de ? addr_a : rd_addr_q;
    flg_b_d   = flg_a;
    flg_c_d   = flg_b_q;
    a0_c_d    = (rd_addr_q == 16'd0);
    bin_d     = flg_c_q.de ? rd_data : 8'd0;
    flg_o_d   = flg_c_q;
    fs_d      = flg_c_q.de && a0_c_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      pix_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      flg_b_q   <= '0;
      flg_c_q   <= '0;
      a0_c_q    <= 1'b0;
      bin_q     <= '0;
      flg_o_q   <= '0;
      fs_q      <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      h_q       <= h_d;
      v_q       <= v_d;
      pix_q     <= pix_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      flg_b_q   <= flg_b_d;
      flg_c_q   <= flg_c_d;
      a0_c_q    <= a0_c_d;
      bin_q     <= bin_d;
      flg_o_q   <= flg_o_d;
      fs_q      <= fs_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign out_bin     = bin_q;
  assign out_de      = flg_o_q.de;
  assign out_hsync   = flg_o_q.hs;
  assign out_vsync   = flg_o_q.vs;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_video_stream_src.sv
// Scoreboard bench for video_stream_src on a small 8x6 raster with mem[a] = a+16.
module tb_video_stream_src;
  localparam int FRM  = 48;
  localparam int NPIX = 12;

  logic        clk = 1'b0;
  logic        rst, ce, enable;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic [7:0]  out_bin;
  logic        out_de, out_hsync, out_vsync, frame_start, busy;
  logic        ce_s = 1'b0;

  int n_chk = 0, n_fail = 0;
  int exp_q[$];
  int phase = 0, mon_phase = 0, ocyc = 0, de_cnt = 0, busy_cnt = 0;
  int last_fs = -1, fs_phase = -1, hs_rise = 0, vs_rise = 0;
  bit throttle = 1'b0, chk_period = 1'b0;
  logic hs_p = 1'b0, vs_p = 1'b0;
  logic [31:0] snap = '0;

  video_stream_src #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .enable(enable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_bin(out_bin), .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync),
    .frame_start(frame_start), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Synchronous-read frame memory, advancing only on ce edges.
  always @(posedge clk) begin
    ce_s <= ce;
    if (ce && rd_en) rd_data <= 8'(rd_addr + 16'd16);
  end

  function automatic logic [31:0] outs();
    return {2'b0, out_bin, out_de, out_hsync, out_vsync, frame_start, busy, rd_en, rd_addr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic mon();
    int e, fs_e;
    forever begin
      @(negedge clk);
      if (phase != mon_phase) begin
        mon_phase = phase;
        de_cnt    = 0;
        busy_cnt  = 0;
      end
      if (!ce_s) begin
        chk("hold", outs(), snap);
      end else begin
        ocyc++;
        snap = outs();
        if (busy) busy_cnt++;
        if (!busy) chk("rd_idle", 32'(rd_en), 0);
        fs_e = 0;
        if (out_de) begin
          de_cnt++;
          if (exp_q.size() == 0) chk("q_underrun", 32'(exp_q.size()), 1);
          else begin
            e = exp_q.pop_front();
            chk("pix", 32'(out_bin), 32'(e));
            fs_e = (e == 16) ? 1 : 0;
          end
        end else chk("bin_blank", 32'(out_bin), 0);
        chk("fs", 32'(frame_start), 32'(fs_e));
        if (frame_start) begin
          if (chk_period && fs_phase == phase) chk("fs_period", 32'(ocyc - last_fs), FRM);
          last_fs  = ocyc;
          fs_phase = phase;
        end
        if (out_hsync && !hs_p) begin
          hs_rise = ocyc;
          if (last_fs >= 0) chk("hs_pos", 32'((ocyc - last_fs) % 8), 5);
        end
        if (!out_hsync && hs_p) chk("hs_w", 32'(ocyc - hs_rise), 2);
        if (out_vsync && !vs_p) begin
          vs_rise = ocyc;
          if (last_fs >= 0) chk("vs_pos", 32'(ocyc - last_fs), 32);
        end
        if (!out_vsync && vs_p) chk("vs_w", 32'(ocyc - vs_rise), 8);
        hs_p = out_hsync;
        vs_p = out_vsync;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ce = throttle ? ~ce : 1'b1;
  endtask

  // Advance until n edges that saw ce=1 have passed.
  task automatic ce_cycles(input int n);
    int k = 0;
    while (k < n) begin
      if (ce) k++;
      tick();
    end
  endtask

  task automatic push_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int i = 0; i < NPIX; i++) exp_q.push_back(16 + i);
  endtask

  task automatic wait_idle(input int bound);
    bit to = 1'b1;
    for (int i = 0; i < bound; i++) begin
      ce_cycles(1);
      if (!busy && exp_q.size() == 0) begin
        to = 1'b0;
        break;
      end
    end
    ce_cycles(6);
    chk("done", 32'(to), 0);
    chk("q_left", 32'(exp_q.size()), 0);
  endtask

  task automatic end_phase(input int frames);
    chk("de_cnt", 32'(de_cnt), 32'(frames * NPIX));
    chk("busy_len", 32'(busy_cnt), 32'(frames * FRM));
  endtask

  initial begin
    bit seen;
    rst = 1'b0; ce = 1'b1; enable = 1'b0;
    #1 chk("rst_state", outs(), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    tick(); tick();
    fork mon(); join_none
    tick();

    // single frame from a one-cycle enable
    phase = 1; chk_period = 1'b0;
    push_frames(1); tick();
    enable = 1'b1; ce_cycles(1); enable = 1'b0;
    wait_idle(400); end_phase(1);

    // continuous enable, three frames back to back
    phase = 2; chk_period = 1'b1;
    push_frames(3); tick();
    enable = 1'b1; ce_cycles(2 * FRM + 1); enable = 1'b0;
    wait_idle(800); end_phase(3);

    // ce toggling; stream in ce time must match the unthrottled run
    phase = 3; throttle = 1'b1;
    push_frames(2); tick();
    enable = 1'b1; ce_cycles(FRM + 1); enable = 1'b0;
    wait_idle(800); throttle = 1'b0; tick(); end_phase(2);

    // enable dropped at v_cnt=1: frame completes
    phase = 4; chk_period = 1'b0;
    push_frames(1); tick();
    enable = 1'b1; ce_cycles(10); enable = 1'b0;
    wait_idle(400); end_phase(1);

    // re-raise during DRAIN: second frame seamless
    phase = 5; chk_period = 1'b1;
    push_frames(2); tick();
    enable = 1'b1; ce_cycles(1); enable = 1'b0;
    ce_cycles(20);
    enable = 1'b1; ce_cycles(28); enable = 1'b0;
    wait_idle(800); end_phase(2);

    // async reset at pixel 5
    phase = 6; chk_period = 1'b0;
    push_frames(1); tick();
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (de_cnt >= 6) seen = 1'b1;
    end
    chk("rst_wait", 32'(seen), 1);
    rst = 1'b0; enable = 1'b0;
    #1 chk("async_rst", outs(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    phase = 7;
    push_frames(1); tick();
    enable = 1'b1; ce_cycles(1); enable = 1'b0;
    wait_idle(400); end_phase(1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
